// File: rtl/dino_pkg.sv
// rtl/dino_pkg.sv - shared dino game constants and FSM encoding
package dino_pkg;

    typedef enum logic [1:0] {
        ST_GROUND  = 2'd0,
        ST_ASCEND  = 2'd1,
        ST_DESCEND = 2'd2
    } dino_state_t;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int GROUND_Y = 400;

endpackage

// File: rtl/dino_sprite_rom.sv
// rtl/dino_sprite_rom.sv - 20x22 two-frame dino bitmap, column 0 is the MSB
module dino_sprite_rom (
    input  logic [4:0] i_row,
    input  logic [4:0] i_col,
    input  logic       i_frame,
    output logic       o_bit
);

    logic [19:0] w_line;

    // Rows 18-21 carry the legs; everything above is shared by both frames.
    always_comb begin
        w_line = '0;
        case (i_row)
            5'd0:  w_line = 20'b00000_00011_11111_10000;
            5'd1:  w_line = 20'b00000_00110_11111_11000;
            5'd2:  w_line = 20'b00000_00111_11111_11000;
            5'd3:  w_line = 20'b00000_00111_11111_11000;
            5'd4:  w_line = 20'b00000_00111_11000_00000;
            5'd5:  w_line = 20'b00000_00111_11111_00000;
            5'd6:  w_line = 20'b10000_01111_11000_00000;
            5'd7:  w_line = 20'b10000_11111_11000_00000;
            5'd8:  w_line = 20'b11001_11111_11110_00000;
            5'd9:  w_line = 20'b11111_11111_11010_00000;
            5'd10: w_line = 20'b11111_11111_11000_00000;
            5'd11: w_line = 20'b01111_11111_11000_00000;
            5'd12: w_line = 20'b00111_11111_11000_00000;
            5'd13: w_line = 20'b00011_11111_10000_00000;
            5'd14: w_line = 20'b00001_11111_10000_00000;
            5'd15: w_line = 20'b00000_11111_00000_00000;
            5'd16: w_line = 20'b00000_11101_10000_00000;
            5'd17: w_line = 20'b00000_11000_10000_00000;
            5'd18: w_line = i_frame ? 20'b00000_01100_10000_00000 : 20'b00000_11000_11000_00000;
            5'd19: w_line = i_frame ? 20'b00000_00000_10000_00000 : 20'b00000_10000_00000_00000;
            5'd20: w_line = i_frame ? 20'b00000_00000_10000_00000 : 20'b00000_10000_00000_00000;
            5'd21: w_line = i_frame ? 20'b00000_00000_11000_00000 : 20'b00000_11000_00000_00000;
            default: w_line = '0;
        endcase
    end

    assign o_bit = (i_col < 5'd20) ? w_line[5'd19 - i_col] : 1'b0;

endmodule

// File: rtl/dino_gen.sv
// rtl/dino_gen.sv - dino jump physics, leg animation and per-pixel sprite flag
module dino_gen #(
    parameter int DINO_X     = 80,
    parameter int GROUND_Y   = dino_pkg::GROUND_Y,
    parameter int DINO_W     = 20,
    parameter int DINO_H     = 22,
    parameter int JUMP_V0    = 12,
    parameter int GRAVITY    = 1,
    parameter int LEG_PERIOD = 6,
    parameter int V_ACTIVE   = dino_pkg::V_ACTIVE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] h_cnt,
    input  logic [9:0] v_cnt,
    input  logic       valid,
    input  logic       jump,
    input  logic       game_run,
    output logic       black_dino,
    output logic [6:0] height,
    output logic       airborne
);
    import dino_pkg::*;

    localparam int LEG_W = (LEG_PERIOD > 1) ? $clog2(LEG_PERIOD) : 1;
    localparam logic [9:0] L_X0   = 10'(DINO_X);
    localparam logic [9:0] L_X1   = 10'(DINO_X + DINO_W);
    localparam logic [9:0] L_BASE = 10'(GROUND_Y - DINO_H);
    localparam logic [9:0] L_H    = 10'(DINO_H);
    localparam logic [9:0] L_VACT = 10'(V_ACTIVE);
    localparam logic [5:0] L_V0   = 6'(JUMP_V0);
    localparam logic [5:0] L_G    = 6'(GRAVITY);
    localparam logic [LEG_W-1:0] L_LEG_LAST = LEG_W'(LEG_PERIOD - 1);

    dino_state_t      r_state;
    logic [6:0]       r_height;
    logic [5:0]       r_spd;
    logic             r_jump_req;
    logic [LEG_W-1:0] r_leg_cnt;
    logic             r_leg_phase;
    logic [9:0]       r_v_cnt_q;
    logic             r_jump_q;

    logic       w_tick;
    logic       w_jump_edge;
    logic [5:0] w_spd_inc;

    assign w_tick      = (v_cnt == L_VACT) && (r_v_cnt_q != L_VACT);
    assign w_jump_edge = jump && !r_jump_q;
    assign w_spd_inc   = r_spd + L_G;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_GROUND;
            r_height    <= '0;
            r_spd       <= '0;
            r_jump_req  <= 1'b0;
            r_leg_cnt   <= '0;
            r_leg_phase <= 1'b0;
            r_v_cnt_q   <= '0;
            r_jump_q    <= 1'b0;
        end else begin
            r_v_cnt_q <= v_cnt;
            r_jump_q  <= jump;
            if (game_run) begin
                // Only a grounded dino may buffer a request, so airborne edges vanish.
                if (r_state != ST_GROUND || w_tick)
                    r_jump_req <= 1'b0;
                else if (w_jump_edge)
                    r_jump_req <= 1'b1;

                if (w_tick) begin
                    case (r_state)
                        ST_GROUND: begin
                            if (r_jump_req) begin
                                r_spd   <= L_V0;
                                r_state <= ST_ASCEND;
                            end
                            if (r_leg_cnt == L_LEG_LAST) begin
                                r_leg_cnt   <= '0;
                                r_leg_phase <= !r_leg_phase;
                            end else begin
                                r_leg_cnt <= r_leg_cnt + 1'b1;
                            end
                        end
                        ST_ASCEND: begin
                            r_height <= r_height + {1'b0, r_spd};
                            if (r_spd > L_G) begin
                                r_spd <= r_spd - L_G;
                            end else begin
                                r_spd   <= L_G;
                                r_state <= ST_DESCEND;
                            end
                        end
                        ST_DESCEND: begin
                            if (r_height <= {1'b0, r_spd}) begin
                                r_height <= '0;
                                r_spd    <= '0;
                                r_state  <= ST_GROUND;
                            end else begin
                                r_height <= r_height - {1'b0, r_spd};
                                r_spd    <= (w_spd_inc > L_V0) ? L_V0 : w_spd_inc;
                            end
                        end
                        default: begin
                            r_height <= '0;
                            r_spd    <= '0;
                            r_state  <= ST_GROUND;
                        end
                    endcase
                end
            end
        end
    end

    logic [9:0] w_top;
    logic [9:0] w_row;
    logic [4:0] w_col;
    logic       w_in_box;
    logic       w_frame;
    logic       w_rom_bit;

    assign w_top    = L_BASE - {3'b000, r_height};
    assign w_row    = v_cnt - w_top;
    assign w_col    = 5'(h_cnt - L_X0);
    assign w_in_box = (h_cnt >= L_X0) && (h_cnt < L_X1) && (v_cnt >= w_top) && (w_row < L_H);
    assign w_frame  = (r_state == ST_GROUND) && r_leg_phase;

    dino_sprite_rom u_rom (
        .i_row   (w_row[4:0]),
        .i_col   (w_col),
        .i_frame (w_frame),
        .o_bit   (w_rom_bit)
    );

    assign black_dino = valid && w_in_box && w_rom_bit;
    assign height     = r_height;
    assign airborne   = (r_state != ST_GROUND);

endmodule
